// File: rtl/fib_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fib_wb_ctrl_if
// Description : Wishbone B4 classic slave bundle for the Fibonacci controller.
//               master drives stb/cyc/we/sel/adr/dat_i and samples
//               ack/dat_o; slave is the mirror image.
//               Signals: wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i[3:0],
//               wbs_adr_i[31:0], wbs_dat_i[31:0], wbs_ack_o, wbs_dat_o[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface fib_wb_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/fib_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fib_wb_ctrl
// Description : Wishbone-slave sequencer for a Fibonacci datapath. Firmware
//               loads COUNT, writes START, then polls STATUS or waits for
//               irq_o and reads RESULT/INDEX. The current term's low bits
//               are driven onto the user pads when IO_EN is set.
// Ports       : wb_clk_i  - clock
//               wb_rst_i  - synchronous active-high reset
//               wb        - Wishbone slave bundle (fib_wb_ctrl_if.slave)
//               io_out    - low IO_BITS of the current term (0 when IO_EN=0)
//               io_oeb    - pad output enables, active low
//               irq_o     - registered DONE & IRQ_EN
// Revision    : 1.0 - initial release
// ============================================================================
module fib_wb_ctrl #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IO_BITS   = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    fib_wb_ctrl_if.slave        wb,
    output logic [IO_BITS-1:0]  io_out,
    output logic [IO_BITS-1:0]  io_oeb,
    output logic                irq_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Register word offsets (byte offset >> 2)
    localparam logic [5:0] c_W_CTRL   = 6'h00;
    localparam logic [5:0] c_W_COUNT  = 6'h01;
    localparam logic [5:0] c_W_STATUS = 6'h02;
    localparam logic [5:0] c_W_RESULT = 6'h03;
    localparam logic [5:0] c_W_INDEX  = 6'h04;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_io_en;
    logic             r_irq_en;
    logic             r_irq;
    logic             r_ovf;
    logic [15:0]      r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH:0]   r_b;
    logic [15:0]      r_idx;

    logic             w_hit;
    logic             w_access;
    logic             w_wr;
    logic [5:0]       w_word;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic             w_wr_count;
    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic             w_step;
    logic             w_block;
    logic [15:0]      w_idx_inc;
    logic [31:0]      w_rd_data;
    logic             w_unused_ok;

    // ------------------------------------------------------------------
    // Bus decode. An access is taken only when no ack is pending, so a
    // strobe still held high during the ack cycle is never serviced twice
    // and ack can never be high on consecutive cycles.
    // ------------------------------------------------------------------
    assign w_hit       = wb.wbs_stb_i & wb.wbs_cyc_i &
                         (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_access    = w_hit & ~r_ack;
    assign w_wr        = w_access & wb.wbs_we_i;
    assign w_word      = wb.wbs_adr_i[7:2];
    assign w_wr_ctrl   = w_wr & (w_word == c_W_CTRL)   & wb.wbs_sel_i[0];
    assign w_wr_status = w_wr & (w_word == c_W_STATUS) & wb.wbs_sel_i[0];
    assign w_wr_count  = w_wr & (w_word == c_W_COUNT)  & ~w_busy;
    assign w_idx_inc   = r_idx + 16'd1;

    assign w_unused_ok = &{1'b0, wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:16],
                           wb.wbs_sel_i[3:2]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = (r_count == 16'd0) ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                // A pending carry in b means the next term no longer fits.
                if (r_b[WIDTH] || (w_idx_inc == r_count)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (w_start) begin
                    w_state_nxt = (r_count == 16'd0) ? c_ST_DONE : c_ST_RUN;
                end else if (w_wr_status && wb.wbs_dat_i[1]) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy  = (r_state == c_ST_RUN);
        w_done  = (r_state == c_ST_DONE);
        w_start = w_wr_ctrl & wb.wbs_dat_i[0] & ~w_busy;
        w_step  = w_busy & ~r_b[WIDTH];
        w_block = w_busy &  r_b[WIDTH];
    end

    // ------------------------------------------------------------------
    // Datapath and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= 16'd0;
            r_ovf    <= 1'b0;
            r_io_en  <= 1'b0;
            r_irq_en <= 1'b0;
            r_count  <= 16'd0;
            r_irq    <= 1'b0;
        end else begin
            if (w_start) begin
                r_a   <= '0;
                r_b   <= (WIDTH+1)'(1);
                r_idx <= 16'd0;
            end else if (w_step) begin
                r_a   <= r_b[WIDTH-1:0];
                r_b   <= {1'b0, r_a} + r_b;
                r_idx <= w_idx_inc;
            end

            if (w_start) begin
                r_ovf <= 1'b0;
            end else if (w_block) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && wb.wbs_dat_i[2]) begin
                r_ovf <= 1'b0;
            end

            if (w_wr_ctrl) begin
                r_io_en  <= wb.wbs_dat_i[1];
                r_irq_en <= wb.wbs_dat_i[2];
            end

            if (w_wr_count && wb.wbs_sel_i[0]) begin
                r_count[7:0] <= wb.wbs_dat_i[7:0];
            end
            if (w_wr_count && wb.wbs_sel_i[1]) begin
                r_count[15:8] <= wb.wbs_dat_i[15:8];
            end

            r_irq <= w_done & r_irq_en;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and bus response
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = 32'd0;
        case (w_word)
            c_W_CTRL:   w_rd_data = {29'd0, r_irq_en, r_io_en, 1'b0};
            c_W_COUNT:  w_rd_data = {16'd0, r_count};
            c_W_STATUS: w_rd_data = {29'd0, r_ovf, w_done, w_busy};
            c_W_RESULT: w_rd_data = 32'(r_a);
            c_W_INDEX:  w_rd_data = {16'd0, r_idx};
            default:    w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_access;
            r_dat <= (w_access && !wb.wbs_we_i) ? w_rd_data : 32'd0;
        end
    end

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
    assign io_out       = r_io_en ? r_a[IO_BITS-1:0] : '0;
    assign io_oeb       = {IO_BITS{~r_io_en}};
    assign irq_o        = r_irq;

endmodule
`default_nettype wire

// File: doc/fib_wb_ctrl.md
Name: fib_wb_ctrl

Overview:
- Wishbone-slave controller that sequences the user-project Fibonacci datapath: the Caravel management core loads a term count, starts a run, polls or takes an interrupt, then reads the result.
- The current term is driven onto the mprj_io user pins, so a firmware-driven caravel bench can check it on the pads.
- Sits inside the user project wrapper, between the Wishbone bus and the mprj_io/irq signals.

Parameters:
- WIDTH, 32, result width in bits (valid range 8..32).
- BASE_ADDR, 32'h3000_0000, Wishbone window base; decode compares wbs_adr_i[31:8].
- IO_BITS, 8, number of mprj_io pins driven with the low bits of the current term.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_out  out  IO_BITS  current term, low bits.
- io_oeb  out  IO_BITS  pad output-enable, active low.
- irq_o  out  1  level interrupt.

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IO_EN, bit2 IRQ_EN.
  - 0x04 COUNT[15:0]: number of steps N.
  - 0x08 STATUS: bit0 BUSY, bit1 DONE, bit2 OVF. DONE and OVF are write-1-to-clear.
  - 0x0C RESULT: register a, zero-extended.
  - 0x10 INDEX[15:0].
  - Other offsets in the window read 0 and ignore writes.
- Bus protocol:
  - Hit = stb & cyc & (adr[31:8] == BASE_ADDR[31:8]).
  - ack asserts the cycle after a hit, lasts exactly one cycle, and is never asserted two cycles in a row.
  - Misses get no ack.
  - wbs_dat_o is valid with ack and is 0 otherwise.
  - Byte lanes are honoured per wbs_sel_i. CTRL and STATUS use sel[0].
- Datapath:
  - a is WIDTH bits; b is WIDTH+1 bits; idx is 16 bits.
  - Invariant: a = F(idx), b = F(idx+1).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - START write with COUNT != 0: a=0, b=1, idx=0, clear DONE/OVF, go to RUN next cycle.
  - START write with COUNT == 0: a=0, idx=0, clear OVF, set DONE, go to DONE.
- RUN, one step per cycle:
  - If b[WIDTH] == 1: the step is blocked, a/b/idx hold, OVF=1, DONE=1, go to DONE.
  - Otherwise: a <= b[WIDTH-1:0], b <= a + b, idx <= idx + 1. If idx + 1 == COUNT: DONE=1, go to DONE.
  - Latency: N cycles from the start-ack cycle to DONE when there is no overflow.
- DONE:
  - Holds results.
  - A new START behaves as in IDLE; START takes priority over a simultaneous W1C in the same write.
  - A W1C of DONE alone returns the FSM to IDLE.
- While BUSY:
  - START and COUNT writes are ignored but still acked.
  - IO_EN/IRQ_EN writes take effect.
- Outputs:
  - io_out = IO_EN ? a[IO_BITS-1:0] : 0.
  - io_oeb = {IO_BITS{~IO_EN}}.
  - irq_o = DONE & IRQ_EN, registered.
- Reset: from any state, including mid-RUN or mid-bus-cycle, all registers, a, b, idx and FSM return to 0/IDLE. Output values after reset:
  - ack = 0, dat = 0
  - io_out = 0, io_oeb = all 1s
  - irq_o = 0

Test Plan:
- Write COUNT=10, write CTRL=0x7, poll STATUS -> DONE set at 10 cycles; RESULT=55, INDEX=10, OVF=0, irq_o=1, io_out=0x37, io_oeb=0x00.
- WIDTH=32: COUNT=47 -> RESULT=2971215073, OVF=0. COUNT=48 -> OVF=1, DONE=1, RESULT=2971215073, INDEX=47.
- COUNT=0 then START -> DONE next cycle, RESULT=0, INDEX=0, BUSY never set.
- During a COUNT=40 run, write COUNT=5 and START -> both acked, run completes with RESULT=102334155, COUNT reads 40.
- Write STATUS=0x2 with IRQ_EN=1 -> irq_o drops the cycle after ack, FSM in IDLE. Write to BASE_ADDR+0x100 -> no ack.
- Assert wb_rst_i mid-RUN for 1 cycle -> next cycle all STATUS bits 0, RESULT 0, io_oeb all 1s, irq_o 0.
